// File: rtl/elementwise_product_accumulator.sv
// Reduces per-lane products to one dot-product sum per vector, with a valid/ready output.
// Define ACC_SATURATE_EN to saturate the accumulator on overflow instead of wrapping.
module elementwise_product_accumulator #(
    parameter int N             = 8,
    parameter int NUM_INSTANCES = 2,
    parameter int ACC_W         = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [2*N*NUM_INSTANCES-1:0]   products,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               out_sum,
    output logic                           out_overflow
);
    localparam int SW = 2*N + $clog2(NUM_INSTANCES);

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t                                state, state_nxt;
    logic [NUM_INSTANCES-1:0][2*N-1:0]     lanes;
    logic [SW-1:0]                         lane_sum;
    logic [SW-1:0]                         s1_sum;
    logic                                  s1_valid, s1_last;
    logic [ACC_W-1:0]                      acc;
    logic                                  overflow;
    logic [ACC_W:0]                        acc_add;
    logic                                  accept;

    assign lanes    = products;
    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign out_sum      = acc;
    assign out_overflow = overflow;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NUM_INSTANCES; i++)
            lane_sum = lane_sum + SW'(lanes[i]);
    end

    // One extra bit so the carry-out marks the overflow.
    assign acc_add = {1'b0, acc} + {{(ACC_W+1-SW){1'b0}}, s1_sum};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_sum    <= '0;
            acc       <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_sum   <= lane_sum;
                s1_valid <= 1'b1;
                s1_last  <= in_last;
            end else begin
                s1_valid <= 1'b0;
            end

            // s1_valid is never set in HOLD, so clearing and accumulating cannot collide.
            if (state == HOLD && out_ready) begin
                acc       <= '0;
                overflow  <= 1'b0;
                out_valid <= 1'b0;
            end else if (s1_valid) begin
`ifdef ACC_SATURATE_EN
                if (acc_add[ACC_W] || overflow) acc <= '1;
                else                            acc <= acc_add[ACC_W-1:0];
`else
                acc <= acc_add[ACC_W-1:0];
`endif
                if (acc_add[ACC_W]) overflow <= 1'b1;
            end

            if (state == DRAIN && s1_valid && s1_last) out_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_elementwise_product_accumulator.sv
// Scoreboard bench: a wide (ACC_W=32) and a narrow (ACC_W=18) instance share all stimulus.
module tb_elementwise_product_accumulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, out_ready;
    logic [31:0] products;
    logic        in_ready, out_valid, out_overflow;
    logic [31:0] out_sum;
    logic        in_ready_b, out_valid_b, out_overflow_b;
    logic [17:0] out_sum_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] s32;
        logic        o32;
        logic [17:0] s18;
        logic        o18;
    } exp_t;

    exp_t   exp_q[$];
    longint m32, m18;
    bit     v32, v18;

    always #5 clk = ~clk;

    elementwise_product_accumulator #(.N(8), .NUM_INSTANCES(2), .ACC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .products(products), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_overflow(out_overflow));

    elementwise_product_accumulator #(.N(8), .NUM_INSTANCES(2), .ACC_W(18)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_last(in_last), .products(products), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sum(out_sum_b), .out_overflow(out_overflow_b));

    task automatic model_clear();
        m32 = 0; m18 = 0; v32 = 0; v18 = 0;
    endtask

    task automatic model_add(input longint s);
        m32 = m32 + s;
        if (m32 >= 64'h1_0000_0000) begin
            v32 = 1;
`ifdef ACC_SATURATE_EN
            m32 = 64'hFFFF_FFFF;
`else
            m32 = m32 - 64'h1_0000_0000;
`endif
        end
        m18 = m18 + s;
        if (m18 >= 64'h4_0000) begin
            v18 = 1;
`ifdef ACC_SATURATE_EN
            m18 = 64'h3_FFFF;
`else
            m18 = m18 - 64'h4_0000;
`endif
        end
    endtask

    // Drives one beat starting at a negedge, returns at the negedge after it is taken.
    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        exp_t e;
        products = {b, a};
        in_valid = 1'b1;
        in_last  = last;
        model_add(longint'(a) + longint'(b));
        if (last) begin
            e.s32 = m32[31:0]; e.o32 = v32; e.s18 = m18[17:0]; e.o18 = v18;
            exp_q.push_back(e);
            model_clear();
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_out(output bit got, output int lat);
        got = 0; lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                got = 1; lat = i;
                return;
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() == 0) begin
            e.s32 = 'x; e.o32 = 'x; e.s18 = 'x; e.o18 = 'x;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_last = 0; products = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_sum !== 32'd0) begin bad++; $display("FAIL reset_out_sum got=%0d want=0", out_sum); end
        total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", out_overflow); end
    endtask

    task automatic test_basic();
        bit got; int lat; exp_t e;
        out_ready = 1'b1;
        beat(16'd12, 16'd30, 1'b0);
        beat(16'd100, 16'd200, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
        get_out(got, lat);
        pop_exp(e);
        total++; if (!got || lat != 1) begin bad++; $display("FAIL basic_latency got=%0d want=1", lat); end
        total++; if (out_sum !== e.s32 || e.s32 !== 32'd342) begin bad++; $display("FAIL basic_sum got=%0d want=342", out_sum); end
        total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%b want=0", out_overflow); end
        @(posedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_one_cycle got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_single();
        bit got; int lat; exp_t e;
        beat(16'hFFFF, 16'h0001, 1'b1);
        get_out(got, lat);
        pop_exp(e);
        total++; if (!got || out_sum !== e.s32) begin bad++; $display("FAIL single_sum got=%h want=%h", out_sum, e.s32); end
        total++; if (out_overflow !== e.o32) begin bad++; $display("FAIL single_overflow got=%b want=%b", out_overflow, e.o32); end
        @(posedge clk); @(negedge clk);
        beat(16'd1, 16'd1, 1'b1);
        get_out(got, lat);
        pop_exp(e);
        total++; if (!got || out_sum !== e.s32) begin bad++; $display("FAIL single_cleared got=%0d want=%0d", out_sum, e.s32); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit got; int lat; exp_t e;
        out_ready = 1'b0;
        beat(16'd3, 16'd4, 1'b0);
        beat(16'd5, 16'd6, 1'b1);
        get_out(got, lat);
        pop_exp(e);
        total++; if (!got || out_sum !== e.s32) begin bad++; $display("FAIL bp_sum got=%0d want=%0d", out_sum, e.s32); end
        products = {16'd9, 16'd9}; in_valid = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_sum !== e.s32 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d valid=%b sum=%0d in_ready=%b want 1/%0d/0", i, out_valid, out_sum, in_ready, e.s32);
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        total++; if (out_sum !== 32'd0) begin bad++; $display("FAIL bp_acc_clear got=%0d want=0", out_sum); end
    endtask

    task automatic test_overflow();
        bit got; int lat; exp_t e;
        logic [17:0] want18;
`ifdef ACC_SATURATE_EN
        want18 = 18'h3FFFF;
`else
        want18 = 18'h1FFFA;
`endif
        beat(16'hFFFF, 16'hFFFF, 1'b0);
        beat(16'hFFFF, 16'hFFFF, 1'b0);
        beat(16'hFFFF, 16'hFFFF, 1'b1);
        get_out(got, lat);
        pop_exp(e);
        total++; if (!got || out_sum_b !== e.s18 || e.s18 !== want18) begin bad++; $display("FAIL ovf_sum18 got=%h want=%h", out_sum_b, want18); end
        total++; if (out_overflow_b !== 1'b1) begin bad++; $display("FAIL ovf_flag18 got=%b want=1", out_overflow_b); end
        total++; if (out_sum !== e.s32 || out_overflow !== e.o32) begin bad++; $display("FAIL ovf_wide got=%h/%b want=%h/%b", out_sum, out_overflow, e.s32, e.o32); end
        @(posedge clk); @(negedge clk);
        total++; if (out_overflow_b !== 1'b0 || out_sum_b !== 18'd0) begin bad++; $display("FAIL ovf_cleared got=%h/%b want=0/0", out_sum_b, out_overflow_b); end
    endtask

    task automatic test_reset_mid();
        bit got; int lat; exp_t e;
        beat(16'd50, 16'd60, 1'b0);
        beat(16'd70, 16'd80, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        beat(16'd5, 16'd7, 1'b1);
        get_out(got, lat);
        pop_exp(e);
        total++; if (!got || out_sum !== e.s32 || e.s32 !== 32'd12) begin bad++; $display("FAIL rstmid_sum got=%0d want=12", out_sum); end
        total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL rstmid_overflow got=%b want=0", out_overflow); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit got; int lat; exp_t e;
        exp_t ne;
        for (int i = 0; i < 4; i++) begin
            products = {16'd2, 16'd1};
            in_valid = 1'b1;
            in_last  = (i == 3);
            model_add(64'd3);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready beat=%0d got=%b want=1", i, in_ready); end
            @(posedge clk); @(negedge clk);
        end
        ne.s32 = m32[31:0]; ne.o32 = v32; ne.s18 = m18[17:0]; ne.o18 = v18;
        exp_q.push_back(ne);
        model_clear();
        in_valid = 1'b0; in_last = 1'b0;
        get_out(got, lat);
        pop_exp(e);
        total++; if (!got || out_sum !== e.s32 || e.s32 !== 32'd12) begin bad++; $display("FAIL b2b_sum got=%0d want=12", out_sum); end
        @(posedge clk); @(negedge clk);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
